uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Frame controller for the UART transmit path. It accepts a parallel byte handshake, sequences the start, data, optional parity and stop bits, and drives the bit-level serializer through `ser_en`/`ser_done`. It multiplexes the serializer's `ser_data` with the framing bits onto the line output `TX_OUT`. It shares `P_DATA`/`data_valid` with the serializer and feeds it `busy`, so both stages load the same byte on the same edge.

## Interface
- `DATA_W`, 8: data bits per frame; must match the serializer width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `P_DATA`  in  8  byte to transmit; sampled only at accept.
- `data_valid`  in  1  request to send `P_DATA`.
- `PAR_EN`  in  1  1 = insert parity bit; sampled at accept.
- `PAR_TYP`  in  1  0 = even, 1 = odd; sampled at accept.
- `ser_data`  in  1  registered serial data bit from the serializer.
- `ser_done`  in  1  one-cycle pulse, coincident with data bit 7 on `ser_data`.
- `ser_en`  out  1  advance enable to the serializer.
- `busy`  out  1  frame in progress; also the serializer load inhibit.
- `TX_OUT`  out  1  UART line, idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state register is the only source of `busy` and of the `TX_OUT` mux select.
- IDLE to START when `data_valid`=1.
  - This is the accept edge: latch `par_en_q`, `par_typ_q`, and `par_bit = ^P_DATA ^ PAR_TYP`.
  - Even parity gives the XOR of the bits; odd parity gives its inverse.
- START to DATA after 1 cycle.
- DATA to PARITY when `ser_done`=1 and `par_en_q`=1; DATA to STOP when `ser_done`=1 and `par_en_q`=0.
- PARITY to STOP after 1 cycle.
- STOP to IDLE after 1 cycle. There is no direct STOP to START transition.
- `ser_en` = (state==START) or (state==DATA and not `ser_done`). `ser_en` is therefore high for exactly 8 cycles per frame.
- `TX_OUT` by state: IDLE=1, START=0, DATA=`ser_data`, PARITY=`par_bit`, STOP=1. The mux is combinational from registered signals only.
- `busy` = (state != IDLE).
- `data_valid` is ignored while `busy`=1. The request is dropped, not queued; the upstream block re-presents it.
- Watchdog: a 4-bit internal counter counts DATA cycles.
  - If it reaches DATA_W+2 without `ser_done`, force STOP.
  - Set sticky internal `frame_err_q`, cleared only by reset; it is debug-visible only.
- Changes to `PAR_EN`/`PAR_TYP`/`P_DATA` mid-frame have no effect on the frame in flight.

## Timing
- Reset: on any edge with `rstn`=0, the next state is IDLE and the counters and `par_bit` clear.
  - Outputs after that edge: `TX_OUT`=1, `busy`=0, `ser_en`=0.
  - Reset mid-frame truncates the line immediately to high; no partial stop bit is sent.
- Accept edge E0: cycle E0+1 is START (`TX_OUT`=0, `busy`=1, `ser_en`=1).
- Cycles E0+2..E0+9 are DATA bits 0..7 (LSB first). `ser_done` is seen at E0+9.
- With parity: E0+10 is PARITY and E0+11 is STOP. Without parity: E0+10 is STOP.
- Back in IDLE at E0+12 (with parity) or E0+11 (without); earliest next accept is on that cycle.
- `data_valid` and `rstn`=0 on the same edge: reset wins.

## Structure
- Package `uart_pkg`: state enum `tx_state_e`, `UART_IDLE_LVL`=1, `UART_START_LVL`=0, `UART_STOP_LVL`=1, `PAR_EVEN`/`PAR_ODD` constants. This package is shared with the RX side.
- Sub-module `parity_calc` (combinational; inputs data and type, output parity bit). It is instantiated once at accept and is reusable by the RX parity checker.
- Top level: the FSM, the watchdog counter, the `TX_OUT` mux, and the serializer instance connection in the parent `uart_tx`.

## Test plan
- Reset held 3 cycles, then released with `data_valid`=0 -> `TX_OUT`=1, `busy`=0, `ser_en`=0 throughout.
- `P_DATA`=8'hA5, `PAR_EN`=1, `PAR_TYP`=0 -> line 0,1,0,1,0,0,1,0,1,0,1 from E0+1; `busy` high for 11 cycles.
- `P_DATA`=8'h01, `PAR_EN`=1, `PAR_TYP`=1 -> parity bit 0 at E0+10; with `PAR_EN`=0 -> STOP at E0+10 and IDLE at E0+11.
- `data_valid` pulsed at E0+4 with 8'hFF -> ignored; the frame carries the original byte and no second frame starts.
- `rstn`=0 at E0+5 -> `TX_OUT`=1 and `busy`=0 from the next cycle; a new accept 2 cycles later sends a complete frame.
- `ser_done` suppressed (stubbed serializer) -> STOP forced after 10 DATA cycles and `frame_err_q`=1; `busy` falls one cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Line levels, parity selectors and TX frame state encoding
//               shared by the UART transmit and receive paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_START  = 3'd1;
    localparam logic [2:0] C_ST_DATA   = 3'd2;
    localparam logic [2:0] C_ST_PARITY = 3'd3;
    localparam logic [2:0] C_ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        TX_IDLE   = C_ST_IDLE,
        TX_START  = C_ST_START,
        TX_DATA   = C_ST_DATA,
        TX_PARITY = C_ST_PARITY,
        TX_STOP   = C_ST_STOP
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
// Module      : parity_calc
// Description : Combinational parity generator, even or odd by type input.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic [DATA_W-1:0] data,
    input  logic              par_typ,
    output logic              par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART TX frame sequencer: start/data/parity/stop FSM, data
//               watchdog and line output mux around an external serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              data_valid,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              ser_data,
    input  logic              ser_done,
    output logic              ser_en,
    output logic              busy,
    output logic              TX_OUT
);

    // Last DATA cycle index before the watchdog gives up (DATA_W+2 cycles)
    localparam logic [3:0] C_WD_LAST = 4'(DATA_W + 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_wd_cnt;
    logic       r_par_bit;
    logic       par_en_q;
    logic       par_typ_q;
    logic       frame_err_q;
    logic       w_par_bit;
    logic       w_accept;
    logic       w_wd_expire;
    logic       w_unused;

    assign w_accept    = (r_state == C_ST_IDLE) && data_valid;
    assign w_wd_expire = (r_state == C_ST_DATA) && !ser_done && (r_wd_cnt == C_WD_LAST);

    // Debug-only state, kept for visibility from the hierarchy
    assign w_unused = ^{par_typ_q, frame_err_q};

    parity_calc #(
        .DATA_W  (DATA_W)
    ) u_parity_calc (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (w_par_bit)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (data_valid) w_state_nxt = C_ST_START;
            end
            C_ST_START: begin
                w_state_nxt = C_ST_DATA;
            end
            C_ST_DATA: begin
                if (ser_done)         w_state_nxt = par_en_q ? C_ST_PARITY : C_ST_STOP;
                else if (w_wd_expire) w_state_nxt = C_ST_STOP;
            end
            C_ST_PARITY: begin
                w_state_nxt = C_ST_STOP;
            end
            C_ST_STOP: begin
                w_state_nxt = C_ST_IDLE;
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= C_ST_IDLE;
            r_wd_cnt    <= '0;
            r_par_bit   <= 1'b0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                r_par_bit <= w_par_bit;
            end
            if (r_state == C_ST_DATA) r_wd_cnt <= r_wd_cnt + 4'd1;
            else                      r_wd_cnt <= '0;
            if (w_wd_expire) frame_err_q <= 1'b1;
        end
    end

    assign busy   = (r_state != C_ST_IDLE);
    assign ser_en = (r_state == C_ST_START) || ((r_state == C_ST_DATA) && !ser_done);

    always_comb begin
        TX_OUT = UART_IDLE_LVL;
        case (r_state)
            C_ST_START:  TX_OUT = UART_START_LVL;
            C_ST_DATA:   TX_OUT = ser_data;
            C_ST_PARITY: TX_OUT = r_par_bit;
            C_ST_STOP:   TX_OUT = UART_STOP_LVL;
            default:     TX_OUT = UART_IDLE_LVL;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench for uart_tx_ctrl with a behavioural
//               serializer and a frame-level line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       busy;
    logic       TX_OUT;

    int n_total = 0;
    int n_pass  = 0;

    bit         stub_done = 1'b0;
    logic [7:0] sr_byte;
    int         sr_idx;

    typedef struct {
        logic [7:0]  d;
        logic        en;
        logic        typ;
        logic [11:0] line;
        int          len;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .busy       (busy),
        .TX_OUT     (TX_OUT)
    );

    // Serializer: loads on the same accept edge, shifts LSB first on ser_en
    always @(posedge clk) begin
        if (!rstn) begin
            ser_data <= 1'b0;
            ser_done <= 1'b0;
            sr_idx   <= 0;
            sr_byte  <= 8'h00;
        end else begin
            ser_done <= 1'b0;
            if (data_valid && !busy) begin
                sr_byte <= P_DATA;
                sr_idx  <= 0;
            end else if (ser_en) begin
                ser_data <= sr_byte[sr_idx[2:0]];
                sr_idx   <= sr_idx + 1;
                if (sr_idx == 7 && !stub_done) ser_done <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " tx"},     TX_OUT, 1'b1);
        check({tag, " busy"},   busy,   1'b0);
        check({tag, " ser_en"}, ser_en, 1'b0);
    endtask

    // Reference frame: start, data LSB first, optional parity, stop
    task automatic model_frame(input logic [7:0] d, input logic en, input logic typ,
                               output logic [11:0] line, output int len);
        int ones = 0;
        logic par;
        for (int b = 0; b < 8; b++) ones += int'(d[b]);
        par  = ((ones % 2) == 1) ^ typ;
        line = '0;
        len  = 0;
        line[len] = 1'b0; len++;
        for (int b = 0; b < 8; b++) begin line[len] = d[b]; len++; end
        if (en) begin line[len] = par; len++; end
        line[len] = 1'b1; len++;
    endtask

    // Accepts a byte and checks every cycle through the return to IDLE.
    // inject > 0 presents a conflicting request on edge E0+inject.
    task automatic run_frame(input logic [7:0] d, input logic en, input logic typ,
                             input logic [11:0] line, input int len,
                             input int inject, input string tag);
        @(negedge clk);
        P_DATA = d; PAR_EN = en; PAR_TYP = typ; data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        P_DATA = ~d; PAR_EN = ~en; PAR_TYP = ~typ;
        for (int i = 1; i <= len + 1; i++) begin
            if (i > 1) begin @(posedge clk); #1; end
            check($sformatf("%s tx c%0d", tag, i),     TX_OUT, (i <= len) ? line[i-1] : 1'b1);
            check($sformatf("%s busy c%0d", tag, i),   busy,   (i <= len));
            check($sformatf("%s ser_en c%0d", tag, i), ser_en, (i <= 8));
            if (inject > 0 && i == inject - 1) begin
                P_DATA = 8'hFF; data_valid = 1'b1;
            end
            if (inject > 0 && i == inject) data_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [11:0] line;
        int          len;
        logic [7:0]  d;
        logic        en, typ;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 12'({1'b1, 1'b0, 8'h01, 1'b0}), 11};
        vecs[2] = '{8'h01, 1'b0, 1'b0, 12'({1'b1,       8'h01, 1'b0}), 10};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 12'({1'b1, 1'b0, 8'hFF, 1'b0}), 11};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 12'({1'b1, 1'b1, 8'h80, 1'b0}), 11};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 12'({1'b1, 1'b1, 8'h00, 1'b0}), 11};
        vecs[6] = '{8'h3C, 1'b0, 1'b1, 12'({1'b1,       8'h3C, 1'b0}), 10};
        vecs[7] = '{8'h7F, 1'b1, 1'b1, 12'({1'b1, 1'b0, 8'h7F, 1'b0}), 11};

        rstn = 1'b0; data_valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("reset c%0d", i));
        end
        check("reset frame_err", dut.frame_err_q, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("post-reset c%0d", i));
        end

        for (int v = 0; v < 8; v++)
            run_frame(vecs[v].d, vecs[v].en, vecs[v].typ, vecs[v].line, vecs[v].len, 0,
                      $sformatf("vec%0d", v));

        // Request while busy is dropped; original A5 frame must go out intact
        run_frame(vecs[0].d, vecs[0].en, vecs[0].typ, vecs[0].line, vecs[0].len, 4, "drop");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("drop after c%0d", i));
        end

        // Watchdog: no ser_done, 10 DATA cycles, then STOP, then IDLE
        stub_done = 1'b1;
        @(negedge clk);
        P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            if (i > 1) begin @(posedge clk); #1; end
            check($sformatf("wd busy c%0d", i),   busy,   (i <= 12));
            check($sformatf("wd ser_en c%0d", i), ser_en, (i <= 11));
            if (i == 1 || i >= 12)
                check($sformatf("wd tx c%0d", i), TX_OUT, (i != 1));
        end
        check("wd frame_err", dut.frame_err_q, 1'b1);
        stub_done = 1'b0;
        run_frame(vecs[3].d, vecs[3].en, vecs[3].typ, vecs[3].line, vecs[3].len, 0, "post-wd");
        check("wd frame_err sticky", dut.frame_err_q, 1'b1);

        // Reset mid-frame truncates the line, then a full frame follows
        @(negedge clk);
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst busy before", busy, 1'b1);
        rstn = 1'b0;
        @(posedge clk); #1;
        check_idle("midrst");
        check("midrst frame_err cleared", dut.frame_err_q, 1'b0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_idle("midrst gap");
        run_frame(vecs[1].d, vecs[1].en, vecs[1].typ, vecs[1].line, vecs[1].len, 0, "midrst new");

        // Reset and request on the same edge: reset wins
        @(negedge clk);
        rstn = 1'b0; data_valid = 1'b1; P_DATA = 8'hC3;
        @(posedge clk); #1;
        check_idle("rst+dv");
        rstn = 1'b1; data_valid = 1'b0;
        @(posedge clk); #1;
        check_idle("rst+dv after");

        // Randomized frames with random idle gaps (0 = back-to-back)
        for (int n = 0; n < 40; n++) begin
            d   = 8'($urandom_range(0, 255));
            en  = 1'($urandom_range(0, 1));
            typ = 1'($urandom_range(0, 1));
            model_frame(d, en, typ, line, len);
            run_frame(d, en, typ, line, len, 0, $sformatf("rnd%0d d=%02h", n, d));
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                @(posedge clk); #1;
                check_idle($sformatf("rnd%0d gap", n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
